// File: rtl/line_stream_formatter.sv
// Line stream formatter: clamps samples off the marker code, appends EOL marker + line number,
// optionally inserts SOF marker pairs, and buffers the result in a FIFO with backpressure.
module line_stream_formatter #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 64,
   parameter int SOF_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sof,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [DATA_W-1:0] line_count,
   output logic              overflow,
   output logic              proto_err,
   input  logic              flag_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [DATA_W-1:0] MARK    = {DATA_W{1'b1}};
   localparam logic [DATA_W-1:0] MARK_M1 = {{(DATA_W-1){1'b1}}, 1'b0};
   localparam logic [DATA_W-1:0] CNT_INC = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0]     PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]       CNT_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]       CNT_FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EOL_NUM,
      S_SOF2
   } state_t;

   state_t            r_state, w_state_next;
   logic              r_sof_pend, w_sof_pend_next;
   logic              r_prev_valid;
   logic              r_stg_valid, w_stg_valid_next;
   logic [DATA_W-1:0] r_stg_data, w_stg_data_next;
   logic [DATA_W-1:0] r_line_count, w_line_count_next;
   logic              r_overflow, r_proto_err;
   logic              w_busy, w_fall, w_accept, w_perr;
   logic [DATA_W-1:0] w_sample;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [AW:0]       r_count;
   logic              w_empty, w_full, w_rd, w_wr, w_drop;

   assign w_sample = (in_data == MARK) ? MARK_M1 : in_data;

   // History tracks accepted samples only, so a dropped stray sample never fakes a line end.
   always_comb begin
      w_busy            = (r_state != S_IDLE) || r_sof_pend;
      w_fall            = r_prev_valid && !in_valid;
      w_accept          = in_valid && !w_busy;
      w_perr            = in_valid && w_busy;
      w_state_next      = r_state;
      w_sof_pend_next   = r_sof_pend;
      w_stg_valid_next  = 1'b0;
      w_stg_data_next   = '0;
      w_line_count_next = r_line_count;
      case (r_state)
         S_IDLE: begin
            if (w_fall) begin
               w_stg_valid_next = 1'b1;
               w_stg_data_next  = MARK;
               w_state_next     = S_EOL_NUM;
               w_sof_pend_next  = r_sof_pend || in_sof;
            end else if (w_accept) begin
               w_stg_valid_next = 1'b1;
               w_stg_data_next  = w_sample;
               w_sof_pend_next  = in_sof;
            end else if (r_sof_pend || in_sof) begin
               w_sof_pend_next = 1'b0;
               if (SOF_EN != 0) begin
                  w_stg_valid_next = 1'b1;
                  w_stg_data_next  = MARK;
                  w_state_next     = S_SOF2;
               end else begin
                  w_line_count_next = '0;
               end
            end
         end
         S_EOL_NUM: begin
            w_stg_valid_next  = 1'b1;
            w_stg_data_next   = r_line_count;
            w_line_count_next = (r_line_count == MARK_M1) ? '0 : r_line_count + CNT_INC;
            w_state_next      = S_IDLE;
            w_sof_pend_next   = r_sof_pend || in_sof;
         end
         S_SOF2: begin
            w_stg_valid_next  = 1'b1;
            w_stg_data_next   = MARK;
            w_line_count_next = '0;
            w_state_next      = S_IDLE;
            w_sof_pend_next   = r_sof_pend || in_sof;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_sof_pend   <= 1'b0;
         r_prev_valid <= 1'b0;
         r_stg_valid  <= 1'b0;
         r_stg_data   <= '0;
         r_line_count <= '0;
      end else begin
         r_state      <= w_state_next;
         r_sof_pend   <= w_sof_pend_next;
         r_prev_valid <= w_accept;
         r_stg_valid  <= w_stg_valid_next;
         r_stg_data   <= w_stg_data_next;
         r_line_count <= w_line_count_next;
      end
   end

   // A read frees a slot in the same cycle, so a full FIFO with a read accepts the write.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_FULL);
   assign w_rd    = !w_empty && out_ready;
   assign w_wr    = r_stg_valid && (!w_full || w_rd);
   assign w_drop  = r_stg_valid && w_full && !w_rd;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= r_stg_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         if (w_wr && !w_rd) begin
            r_count <= r_count + CNT_ONE;
         end else if (!w_wr && w_rd) begin
            r_count <= r_count - CNT_ONE;
         end
      end
   end

   // Sticky flags: a new event in the same cycle as flag_clr keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (flag_clr) begin
            r_overflow <= 1'b0;
         end
         if (w_perr) begin
            r_proto_err <= 1'b1;
         end else if (flag_clr) begin
            r_proto_err <= 1'b0;
         end
      end
   end

   assign out_valid  = !w_empty;
   assign out_data   = w_empty ? '0 : r_mem[r_rd_ptr];
   assign line_count = r_line_count;
   assign overflow   = r_overflow;
   assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_line_stream_formatter.sv
// Bench for line_stream_formatter: directed scenarios plus randomized lines, checked against a
// queue-based reference model of the word stream and the output buffer.
module tb_line_stream_formatter;

   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam logic [DW-1:0] MARK = 16'hFFFF;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_sof, out_ready, flag_clr;
   logic [DW-1:0] in_data;
   logic          out_valid, overflow, proto_err;
   logic [DW-1:0] out_data, line_count;

   always #5 clk = ~clk;

   line_stream_formatter #(.DATA_W(DW), .DEPTH(DEPTH), .SOF_EN(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_sof     (in_sof),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .line_count (line_count),
      .overflow   (overflow),
      .proto_err  (proto_err),
      .flag_clr   (flag_clr)
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc     = 0;

   // Reference model: pending insertion words, one-word stage, output buffer, counters, flags.
   logic [DW-1:0] ins_q[$];
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] dut_got[$];
   logic [DW-1:0] exp_q[$];
   logic          m_stg_v, m_prev, m_ovf, m_perr;
   logic [DW-1:0] m_stg_d, m_cnt;

   bit rand_mode = 0;
   int ready_pct = 100;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_step();
      logic          rd, busy, accepted, gen_v, ovf_evt, perr_evt;
      logic [DW-1:0] gen;
      if (rst) begin
         ins_q.delete();
         fifo_q.delete();
         m_stg_v = 0; m_stg_d = '0; m_prev = 0; m_cnt = '0; m_ovf = 0; m_perr = 0;
         return;
      end
      rd       = (fifo_q.size() > 0) && out_ready;
      busy     = (ins_q.size() > 0);
      perr_evt = in_valid && busy;
      accepted = 0; gen_v = 0; gen = '0; ovf_evt = 0;
      if (in_valid && !busy) begin
         accepted = 1;
         gen_v    = 1;
         gen      = (in_data == MARK) ? MARK - 16'd1 : in_data;
      end else begin
         if (m_prev && !in_valid) begin
            ins_q.push_back(MARK);
            ins_q.push_back(m_cnt);
            m_cnt = (m_cnt == MARK - 16'd1) ? 16'd0 : m_cnt + 16'd1;
         end
         if (in_sof) begin
            ins_q.push_back(MARK);
            ins_q.push_back(MARK);
            m_cnt = 16'd0;
         end
         if (ins_q.size() > 0) begin
            gen_v = 1;
            gen   = ins_q.pop_front();
         end
      end
      m_prev = accepted;
      if (rd) void'(fifo_q.pop_front());
      if (m_stg_v) begin
         if (fifo_q.size() < DEPTH) fifo_q.push_back(m_stg_d);
         else ovf_evt = 1;
      end
      m_stg_v = gen_v;
      m_stg_d = gen;
      m_ovf   = ovf_evt  ? 1'b1 : (flag_clr ? 1'b0 : m_ovf);
      m_perr  = perr_evt ? 1'b1 : (flag_clr ? 1'b0 : m_perr);
   endtask

   task automatic compare_model();
      check_val("out_valid", out_valid, fifo_q.size() > 0);
      check_val("out_data", out_data, (fifo_q.size() > 0) ? fifo_q[0] : 16'd0);
      check_val("overflow", overflow, m_ovf);
      check_val("proto_err", proto_err, m_perr);
      if (ins_q.size() == 0) check_val("line_count", line_count, m_cnt);
   endtask

   task automatic tick();
      if (rand_mode) begin
         out_ready = ($urandom_range(99) < ready_pct);
         flag_clr  = ($urandom_range(99) < 4);
      end
      if (out_valid && out_ready && !rst) begin
         dut_got.push_back(out_data);
         $display("[TB] cycle %0d word %h", cyc, out_data);
      end
      @(posedge clk);
      model_step();
      #1;
      compare_model();
      cyc++;
   endtask

   task automatic idle(input int n);
      in_valid = 0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input logic [DW-1:0] d);
      in_valid = 1;
      in_data  = d;
      tick();
      in_valid = 0;
   endtask

   task automatic expw(input logic [DW-1:0] v);
      exp_q.push_back(v);
   endtask

   task automatic expect_seq(input string tag);
      check_val({tag, "_len"}, dut_got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < dut_got.size(); i++)
         check_val(tag, dut_got[i], exp_q[i]);
      dut_got.delete();
      exp_q.delete();
   endtask

   initial begin
      rst = 1; in_valid = 0; in_data = '0; in_sof = 0; out_ready = 1; flag_clr = 0;
      #1;
      tick(); tick();
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_out_data", out_data, 0);
      check_val("rst_line_count", line_count, 0);
      rst = 0;
      idle(2);

      // Basic line with clamp, EOL and latency
      in_valid = 1; in_data = 16'd10; tick();
      check_val("lat_n1", out_valid, 0);
      in_data = 16'd20; tick();
      check_val("lat_n2", out_valid, 1);
      check_val("lat_first", out_data, 16'd10);
      in_data = 16'hFFFF; tick();
      in_data = 16'd30; tick();
      idle(6);
      expw(10); expw(20); expw(16'hFFFE); expw(30); expw(MARK); expw(0);
      expect_seq("t1_seq");
      check_val("t1_count", line_count, 1);

      // Falling edge coincident with SOF, then a fresh line numbered 0
      send(16'd1); send(16'd2);
      in_sof = 1; tick(); in_sof = 0;
      idle(6);
      check_val("t3_count", line_count, 0);
      check_val("t3_perr", proto_err, 0);
      send(16'd5); idle(5);
      expw(1); expw(2); expw(MARK); expw(1); expw(MARK); expw(MARK); expw(5); expw(MARK); expw(0);
      expect_seq("t3_seq");
      check_val("t3_count2", line_count, 1);

      // Sample re-asserted right after a falling edge is dropped
      send(16'd7); send(16'd8);
      tick();
      send(16'd99);
      idle(5);
      check_val("t4_perr_set", proto_err, 1);
      send(16'd9); idle(5);
      expw(7); expw(8); expw(MARK); expw(1); expw(9); expw(MARK); expw(2);
      expect_seq("t4_seq");
      flag_clr = 1; tick(); flag_clr = 0; tick();
      check_val("t4_perr_clr", proto_err, 0);

      // Overflow with a stalled output
      out_ready = 0;
      for (int i = 0; i < 12; i++) send(16'(i + 1));
      idle(4);
      check_val("t5_ovf", overflow, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("t5_hold", out_data, 16'd1);
      end
      out_ready = 1;
      idle(12);
      for (int i = 0; i < 8; i++) expw(16'(i + 1));
      expect_seq("t5_seq");
      check_val("t5_count", line_count, 4);
      flag_clr = 1; tick(); flag_clr = 0; tick();
      check_val("t5_ovf_clr", overflow, 0);

      // Reset in the middle of a line
      out_ready = 0;
      send(16'd40); send(16'd41); send(16'd42);
      in_valid = 1; in_data = 16'd43; rst = 1; tick();
      rst = 0; in_valid = 0;
      check_val("t6_out_valid", out_valid, 0);
      check_val("t6_count", line_count, 0);
      idle(3);
      out_ready = 1;
      send(16'd3); send(16'd4); idle(6);
      expw(3); expw(4); expw(MARK); expw(0);
      expect_seq("t6_seq");

      // Randomized lines against the model
      rand_mode = 1;
      for (int ln = 0; ln < 60; ln++) begin
         int len, gap, sof_at, glitch_at;
         ready_pct = (ln % 10 < 2) ? 15 : 85;
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) begin
            int sel = $urandom_range(0, 9);
            in_valid = 1;
            in_data  = (sel == 0) ? MARK : (sel == 1) ? MARK - 16'd1 : 16'($urandom);
            tick();
         end
         in_valid  = 0;
         gap       = $urandom_range(3, 6);
         sof_at    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
         glitch_at = ($urandom_range(0, 7) == 0) ? 1 : -1;
         if (glitch_at == sof_at) sof_at = 0;
         if (glitch_at >= 0) gap = gap + 3;
         for (int g = 0; g < gap; g++) begin
            in_sof   = (g == sof_at);
            in_valid = (g == glitch_at);
            in_data  = 16'($urandom);
            tick();
         end
         in_sof = 0; in_valid = 0;
      end
      rand_mode = 0;
      out_ready = 1; flag_clr = 0;
      idle(DEPTH + 6);
      check_val("final_empty", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
